// File: rtl/sdram_bist_master.sv
// Memory BIST initiator: writes an LFSR pattern over a word range through
// the request/accept interface, reads it back and compares each word.
module sdram_bist_master #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          NUM_WORDS      = 1024,
  parameter logic [31:0] LFSR_SEED      = 32'hACE12468,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH/8-1:0] wr,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    rd,
  input  logic                    accept,
  input  logic                    rvalid,
  input  logic [DATA_WIDTH-1:0]   read_data
);

  localparam int BE = DATA_WIDTH / 8;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]         LAST = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0]         TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BE);
  localparam logic [31:0]           TAPS = 32'h80200003;

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [31:0]     lfsr;
  logic [TW-1:0]   wcnt;

  logic [31:0]           lfsr_next;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  last;
  logic                  rd_take;
  logic                  mismatch;
  logic                  waited;
  logic [15:0]           err_next;

  // Wider buses replicate the 32-bit LFSR word, narrower ones take its low bits.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] l);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) p[i] = l[i % 32];
    return p;
  endfunction

  always_comb begin
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : '0);
    exp_word  = pattern(lfsr);
    next_word = pattern(lfsr_next);
    last      = (idx == LAST);
    // rvalid counts in RD_WAIT, or together with the accept that takes the read
    rd_take   = ((state == RD_REQ) && accept && rvalid) ||
                ((state == RD_WAIT) && rvalid);
    mismatch  = rd_take && (read_data != exp_word);
    err_next  = (mismatch && (err_count != '1)) ? err_count + 16'd1 : err_count;
    waited    = (wcnt == TLIM);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      lfsr           <= '0;
      wcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      addr           <= '0;
      wr             <= '0;
      write_data     <= '0;
      rd             <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            idx            <= '0;
            lfsr           <= LFSR_SEED;
            wcnt           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            addr           <= BASE;
            wr             <= '1;
            write_data     <= pattern(LFSR_SEED);
          end
        end
        WRITE: begin
          if (accept) begin
            wcnt <= '0;
            if (last) begin
              state <= RD_REQ;
              idx   <= '0;
              lfsr  <= LFSR_SEED;
              wr    <= '0;
              rd    <= 1'b1;
              addr  <= BASE;
            end else begin
              idx        <= idx + 1'b1;
              lfsr       <= lfsr_next;
              addr       <= addr + STEP;
              write_data <= next_word;
            end
          end else if (waited) begin
            state   <= DONE;
            wr      <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RD_REQ, RD_WAIT: begin
          if (rd_take) begin
            wcnt      <= '0;
            err_count <= err_next;
            if (mismatch && (err_count == '0)) first_err_addr <= addr;
            if (last) begin
              state <= DONE;
              rd    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state <= RD_REQ;
              idx   <= idx + 1'b1;
              lfsr  <= lfsr_next;
              addr  <= addr + STEP;
              rd    <= 1'b1;
            end
          end else if ((state == RD_REQ) && accept) begin
            wcnt  <= '0;
            rd    <= 1'b0;
            state <= RD_WAIT;
          end else if (waited) begin
            state   <= DONE;
            rd      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bist_master.sv
// Directed bench for sdram_bist_master: a 4-word responder model with stall,
// corruption and lost-read modes, plus a 64-bit wrapping instance.
module tb_sdram_bist_master;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, addr, write_data, read_data;
  logic [3:0]  wr;
  logic        rd, accept, rvalid;

  logic        start2;
  logic        busy2, done2, pass2, timeout2;
  logic [15:0] err_count2;
  logic [31:0] first_err_addr2, addr2;
  logic [7:0]  wr2;
  logic [63:0] write_data2, read_data2;
  logic        rd2;
  logic        accept2, rvalid2;

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;

  // Hand-derived LFSR sequence from seed 0xACE12468, taps 0x80200003.
  logic [31:0] exp_w [8] = '{32'hACE12468, 32'h56709234, 32'h2B38491A, 32'h159C248D,
                             32'h8AEE1245, 32'hC5570921, 32'h0, 32'h0};
  logic [31:0] exp_a2 [6] = '{32'hFFFFFFF0, 32'hFFFFFFF8, 32'h0, 32'h8, 32'h10, 32'h18};

  sdram_bist_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .NUM_WORDS(4),
    .LFSR_SEED(32'hACE12468), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .addr(addr), .wr(wr), .write_data(write_data), .rd(rd), .accept(accept),
    .rvalid(rvalid), .read_data(read_data)
  );

  sdram_bist_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BASE_ADDR(32'hFFFFFFF0), .NUM_WORDS(6),
    .LFSR_SEED(32'hACE12468), .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .timeout(timeout2), .err_count(err_count2), .first_err_addr(first_err_addr2),
    .addr(addr2), .wr(wr2), .write_data(write_data2), .rd(rd2), .accept(accept2),
    .rvalid(rvalid2), .read_data(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder for dut: 4-word memory, optional accept stalls, bit flip, lost reads.
  logic [31:0] mem [4];
  int          stall_n = 0;
  bit          flip8   = 0;
  bit          no_rv   = 0;
  int          scnt    = 0;
  int          rv_cnt  = 0;
  logic [31:0] rv_addr;
  bit          prev_stall = 0;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_wr;
  logic        p_rd;
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          wc_q [$];

  initial begin
    accept = 1'b0; rvalid = 1'b0; read_data = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      scnt = 0; rv_cnt = 0; accept = 1'b0; rvalid = 1'b0; prev_stall = 0;
    end else begin
      rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0 && !no_rv) begin
          rvalid    = 1'b1;
          read_data = mem[rv_addr[3:2]] ^ ((flip8 && rv_addr == 32'h8) ? 32'h1 : 32'h0);
        end
      end
      if (prev_stall) begin
        check("stall_addr_stable", addr, p_addr);
        check("stall_wr_stable", wr, p_wr);
        check("stall_wdata_stable", write_data, p_wd);
        check("stall_rd_stable", rd, p_rd);
      end
      if (wr != 0 || rd) begin
        if (scnt < stall_n) begin
          accept = 1'b0; scnt++; prev_stall = 1;
          p_addr = addr; p_wr = wr; p_wd = write_data; p_rd = rd;
        end else begin
          accept = 1'b1; scnt = 0; prev_stall = 0;
          if (wr != 0) begin
            mem[addr[3:2]] = write_data;
            wa_q.push_back(addr); wd_q.push_back(write_data); wc_q.push_back(cyc);
          end else begin
            rv_cnt = 2; rv_addr = addr;
          end
        end
      end else begin
        accept = (stall_n == 0);
        prev_stall = 0;
      end
    end
  end

  // dut2 sees accept and rvalid permanently high; read data comes from the table.
  int          w2 = 0;
  int          r2 = 0;
  logic [31:0] a2off;
  assign accept2    = 1'b1;
  assign rvalid2    = 1'b1;
  assign a2off      = addr2 + 32'd16;
  assign read_data2 = {exp_w[a2off[5:3]], exp_w[a2off[5:3]]};

  always @(negedge clk) begin
    if (rst && wr2 != 0) begin
      check("d2_wr_en", wr2, 8'hFF);
      if (w2 < 6) begin
        check("d2_wr_addr", addr2, exp_a2[w2]);
        check("d2_wr_data", write_data2, {exp_w[w2], exp_w[w2]});
      end
      w2++;
    end
    if (rst && rd2) r2++;
  end

  task automatic wait_done(input bit which, input int budget, input string tag);
    int n = 0;
    while (!(which ? done2 : done) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check(tag, which ? done2 : done, 1'b1);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_first_wr"}, wr, 4'hF);
    check({tag, "_first_addr"}, addr, 32'h0);
    check({tag, "_first_wdata"}, write_data, exp_w[0]);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_done_clr"}, done, 1'b0);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_trace(input string tag, input int spacing);
    check({tag, "_nwrites"}, wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa_q.size()) begin
        check({tag, "_waddr"}, wa_q[i], 32'(i * 4));
        check({tag, "_wdata"}, wd_q[i], exp_w[i]);
        if (i > 0) check({tag, "_wspacing"}, wc_q[i] - wc_q[i-1], spacing);
      end
    end
  endtask

  task automatic clear_trace();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_err", err_count, 16'h0);
    check("rst_fea", first_err_addr, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wr", wr, 4'h0);
    check("rst_wdata", write_data, 32'h0);
    check("rst_rd", rd, 1'b0);
    @(negedge clk) rst = 1'b1;

    // 64-bit replicated pattern, wrapping address, same-cycle rvalid
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    wait_done(1, 100, "d2_done");
    check("d2_pass", pass2, 1'b1);
    check("d2_err", err_count2, 16'h0);
    check("d2_timeout", timeout2, 1'b0);
    check("d2_fea", first_err_addr2, 32'h0);
    check("d2_busy", busy2, 1'b0);
    check("d2_nwrites", w2, 6);
    check("d2_nreads", r2, 6);

    // Ideal responder
    clear_trace();
    pulse_start("t1");
    wait_done(0, 200, "t1_done");
    check("t1_pass", pass, 1'b1);
    check("t1_err", err_count, 16'h0);
    check("t1_timeout", timeout, 1'b0);
    check("t1_fea", first_err_addr, 32'h0);
    check("t1_busy", busy, 1'b0);
    check("t1_rd", rd, 1'b0);
    check_trace("t1", 1);
    repeat (5) @(posedge clk);
    #1;
    check("t1_done_held", done, 1'b1);

    // Corrupted word at 0x8
    flip8 = 1;
    pulse_start("t2");
    wait_done(0, 200, "t2_done");
    check("t2_err", err_count, 16'h1);
    check("t2_fea", first_err_addr, 32'h8);
    check("t2_pass", pass, 1'b0);
    check("t2_timeout", timeout, 1'b0);
    flip8 = 0;

    // Three-cycle accept stalls, plus start pulsed while busy
    stall_n = 3;
    clear_trace();
    pulse_start("t3");
    repeat (8) @(posedge clk);
    @(negedge clk) start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(0, 500, "t3_done");
    check("t3_pass", pass, 1'b1);
    check("t3_err", err_count, 16'h0);
    check_trace("t3", 4);
    stall_n = 0;

    // Lost read: timeout 16 cycles after the read accept
    no_rv = 1;
    pulse_start("t4");
    begin
      int n = 0;
      while (!rd && n < 100) begin @(posedge clk); #1; n++; end
      check("t4_rd_seen", rd, 1'b1);
    end
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    check("t4_not_early", done, 1'b0);
    @(posedge clk); #1;
    check("t4_done", done, 1'b1);
    check("t4_timeout", timeout, 1'b1);
    check("t4_rd", rd, 1'b0);
    check("t4_pass", pass, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_err", err_count, 16'h0);
    no_rv = 0;

    // Reset mid-write, then a clean rerun
    pulse_start("t5");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_wr", wr, 4'h0);
    check("t5_rst_rd", rd, 1'b0);
    check("t5_rst_addr", addr, 32'h0);
    check("t5_rst_wdata", write_data, 32'h0);
    check("t5_rst_timeout", timeout, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_done", done, 1'b0);
    check("t5_idle_busy", busy, 1'b0);
    clear_trace();
    pulse_start("t5r");
    wait_done(0, 200, "t5_done");
    check("t5_pass", pass, 1'b1);
    check("t5_timeout", timeout, 1'b0);
    check("t5_err", err_count, 16'h0);
    check_trace("t5", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
